ssf_stream_ctrl: RTL and testbench
==================================

Name: ssf_stream_ctrl

Overview:
Sequencer that wraps the SSF filter core and connects it to ready/valid sample streams. Buffers input samples and presents one sample per core request. Captures each core output word into an output buffer. Holds the core in reset until the first sample is primed, and counts underrun and overrun events for debug.

Parameters:
DATA_W, 32, signed sample width on every data path
IN_DEPTH, 16, input FIFO depth in words (power of 2, minimum 2)
OUT_DEPTH, 16, output FIFO depth in words (power of 2, minimum 2)
CNT_W, 16, width of status counters

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin a run
stop  in  1  one-cycle pulse: end the run after the drain completes
s_data  in  DATA_W  signed input sample
s_valid  in  1  input sample valid
s_ready  out  1  input FIFO not full
m_data  out  DATA_W  signed output sample (head of output FIFO)
m_valid  out  1  output FIFO not empty
m_ready  in  1  downstream accepts m_data
core_rst_n  out  1  active-low reset to core; 0 except in RUN/DRAIN
core_in  out  DATA_W  registered sample presented to core
core_req  in  2  core input request; value 2'd1 = consume current sample
core_out  in  DATA_W  core output word
core_out_en  in  2  core output strobe; value 2'd1 = core_out valid
busy  out  1  state != IDLE
underrun_cnt  out  CNT_W  requests seen with input FIFO empty (saturating)
overrun_cnt  out  CNT_W  core outputs dropped because output FIFO full (saturating)
sample_cnt  out  CNT_W  core outputs written to output FIFO (wrapping)

Behaviour:
- Reset values: state=IDLE; both FIFOs empty; core_in=0; core_rst_n=0; s_ready=1; m_valid=0; m_data=0; busy=0; all counters 0.
- FSM states: IDLE, PRIME, RUN, DRAIN.
  - IDLE -> PRIME on start. Counters clear on this transition.
  - PRIME: when the input FIFO is non-empty, pop it into core_in, then go to RUN. core_rst_n is driven 1 from the cycle after the pop.
  - RUN -> DRAIN on stop.
  - DRAIN: the input side keeps serving requests until the input FIFO is empty. Then go to IDLE.
  - On entering IDLE, core_rst_n drops to 0. Output FIFO contents are retained.
- start is ignored outside IDLE. stop is ignored outside RUN. A stop in PRIME is ignored.
- Input FIFO:
  - Push when s_valid && s_ready.
  - s_ready = !full, combinational from FIFO occupancy.
  - Pushes are accepted in every state, including IDLE.
- Core request handling (RUN or DRAIN only):
  - Request condition: rising edge with core_req==2'd1.
  - FIFO non-empty: pop, and core_in <= head. The new value is visible the cycle after the request edge.
  - FIFO empty: core_in holds its value and underrun_cnt increments (saturating).
  - A push and a pop in the same cycle are both honoured, including at full and at empty. At empty, the pushed word is not bypassed to the pop; that request counts as an underrun.
  - core_req values 0, 2 and 3 are no-ops.
- Output capture (RUN or DRAIN only):
  - On a rising edge with core_out_en==2'd1 and output FIFO not full: push core_out and increment sample_cnt.
  - If the output FIFO is full, drop the word and increment overrun_cnt.
  - A simultaneous pop (m_valid && m_ready) in the same cycle frees space, so a push in that cycle succeeds.
- Output interface: m_data/m_valid come directly from the FIFO head (show-ahead, zero-latency). m_data holds stable while m_valid && !m_ready.
- Arithmetic: no data modification; samples pass bit-exact in two's-complement. FIFO pointers are log2(DEPTH)+1 bits, with full/empty decided by the MSB compare.
- Reset mid-operation (rst_n low at any time):
  - Immediate return to the reset values above; FIFO contents are discarded.
  - core_rst_n goes low asynchronously.
- Latency: s_data accepted at edge N is at the FIFO head by edge N+1. core_out strobed at edge N shows m_valid=1 after edge N.

Test Plan:
- Basic flow: push 5, -3, 7; pulse start; core_req=2'd1 on 3 edges -> core_in sequence 5 (at PRIME), -3, 7; core_rst_n=1 from the cycle after the first pop; underrun_cnt=0.
- Underrun: after the FIFO empties, assert core_req=2'd1 for 4 edges -> core_in holds 7 and underrun_cnt=4. Then push 9 and assert one request -> core_in=9.
- Output overrun: hold m_ready=0 and strobe core_out_en=2'd1 with values 1..OUT_DEPTH+2 -> first 16 stored, overrun_cnt=2, sample_cnt=16. Then drain with m_ready=1 -> m_data reads 1..16 in order.
- Simultaneous push/pop at full: input FIFO full, s_valid=1 and core request on the same edge -> one word enters, one leaves, occupancy stays 16, s_ready stays 0.
- Stop/drain: in RUN with 3 words queued, pulse stop -> busy stays 1 until 3 more requests pop all words, then state=IDLE and core_rst_n=0. A stop pulse in IDLE has no effect.
- Async reset mid-run: drop rst_n between edges -> core_rst_n=0 and m_valid=0 immediately; after release all counters are 0 and s_ready=1.

Source files
------------

// File: rtl/ssf_stream_ctrl.sv
// rtl/ssf_stream_ctrl.sv - stream sequencer wrapping the SSF filter core
//
// ssf_fifo: show-ahead FIFO used for both sample queues.
//   push/wdata : write request; taken when not full, or when full and a pop
//                is taken in the same cycle
//   pop        : read request; taken when not empty
//   rdata      : head word (zero when empty), empty/full : occupancy flags
//
// ssf_stream_ctrl: feeds buffered input samples to the core on request and
// buffers core output words for the downstream consumer.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   start, stop                 : run control pulses
//   s_data/s_valid/s_ready      : input sample stream
//   m_data/m_valid/m_ready      : output sample stream
//   core_rst_n, core_in         : core reset and presented sample
//   core_req, core_out(_en)     : core request and output strobe (2'd1 = active)
//   busy                        : sequencer not idle
//   underrun_cnt, overrun_cnt   : saturating debug counters
//   sample_cnt                  : wrapping count of captured core outputs

module ssf_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         pop_ok;
    logic         push_ok;

    // Pointers carry one extra wrap bit: equal => empty, only MSB differs => full.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end
endmodule

module ssf_stream_ctrl #(
    parameter int DATA_W    = 32,
    parameter int IN_DEPTH  = 16,
    parameter int OUT_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              core_rst_n,
    output logic [DATA_W-1:0] core_in,
    input  logic [1:0]        core_req,
    input  logic [DATA_W-1:0] core_out,
    input  logic [1:0]        core_out_en,
    output logic              busy,
    output logic [CNT_W-1:0]  underrun_cnt,
    output logic [CNT_W-1:0]  overrun_cnt,
    output logic [CNT_W-1:0]  sample_cnt
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic              active;
    logic              req_hit;
    logic              in_pop;
    logic              in_empty;
    logic              in_full;
    logic [DATA_W-1:0] in_head;
    logic              out_strobe;
    logic              out_full;
    logic              out_empty;
    logic              m_pop;
    logic              underrun_evt;
    logic              overrun_evt;
    logic              capture_evt;
    logic              cnt_clear;

    assign active    = (state == RUN) || (state == DRAIN);
    assign req_hit   = active && (core_req == 2'd1);
    // PRIME loads the first sample on its own; afterwards only core requests pop.
    assign in_pop    = ((state == PRIME) && !in_empty) || (req_hit && !in_empty);
    assign s_ready   = !in_full;

    assign out_strobe = active && (core_out_en == 2'd1);
    assign m_valid    = !out_empty;
    assign m_pop      = m_valid && m_ready;

    assign underrun_evt = req_hit && in_empty;
    assign overrun_evt  = out_strobe && out_full && !m_pop;
    assign capture_evt  = out_strobe && !overrun_evt;
    assign cnt_clear    = (state == IDLE) && start;

    assign busy = (state != IDLE);

    ssf_fifo #(.W(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s_valid),
        .wdata (s_data),
        .pop   (in_pop),
        .rdata (in_head),
        .empty (in_empty),
        .full  (in_full)
    );

    ssf_fifo #(.W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (out_strobe),
        .wdata (core_out),
        .pop   (m_pop),
        .rdata (m_data),
        .empty (out_empty),
        .full  (out_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            core_rst_n <= 1'b0;
            core_in    <= '0;
        end else begin
            if (in_pop) begin
                core_in <= in_head;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= PRIME;
                    end
                end
                PRIME: begin
                    if (!in_empty) begin
                        state      <= RUN;
                        core_rst_n <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (in_empty) begin
                        state      <= IDLE;
                        core_rst_n <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    core_rst_n <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= '0;
            overrun_cnt  <= '0;
            sample_cnt   <= '0;
        end else if (cnt_clear) begin
            underrun_cnt <= '0;
            overrun_cnt  <= '0;
            sample_cnt   <= '0;
        end else begin
            if (underrun_evt && (underrun_cnt != CNT_MAX)) begin
                underrun_cnt <= underrun_cnt + CNT_ONE;
            end
            if (overrun_evt && (overrun_cnt != CNT_MAX)) begin
                overrun_cnt <= overrun_cnt + CNT_ONE;
            end
            if (capture_evt) begin
                sample_cnt <= sample_cnt + CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_ssf_stream_ctrl.sv
// tb/tb_ssf_stream_ctrl.sv - directed self-checking bench for ssf_stream_ctrl

module tb_ssf_stream_ctrl;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        core_rst_n;
    logic [31:0] core_in;
    logic [1:0]  core_req;
    logic [31:0] core_out;
    logic [1:0]  core_out_en;
    logic        busy;
    logic [15:0] underrun_cnt;
    logic [15:0] overrun_cnt;
    logic [15:0] sample_cnt;

    int errors = 0;
    int checks = 0;

    ssf_stream_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .core_rst_n   (core_rst_n),
        .core_in      (core_in),
        .core_req     (core_req),
        .core_out     (core_out),
        .core_out_en  (core_out_en),
        .busy         (busy),
        .underrun_cnt (underrun_cnt),
        .overrun_cnt  (overrun_cnt),
        .sample_cnt   (sample_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        s_data      = '0;
        s_valid     = 1'b0;
        m_ready     = 1'b0;
        core_req    = 2'd0;
        core_out    = '0;
        core_out_en = 2'd0;
        step();

        // Reset state
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("rst_core_in", core_in, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_underrun", 32'(underrun_cnt), 32'd0);
        chk("rst_sample", 32'(sample_cnt), 32'd0);
        rst_n = 1'b1;

        // Basic flow: pushes accepted in IDLE, PRIME loads 5, requests give -3, 7
        s_valid = 1'b1;
        s_data = 32'd5;  step();
        s_data = -32'sd3; step();
        s_data = 32'd7;  step();
        s_valid = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        chk("prime_busy", 32'(busy), 32'd1);
        chk("prime_core_rst_n", 32'(core_rst_n), 32'd0);
        step();
        chk("prime_core_in", core_in, 32'd5);
        chk("run_core_rst_n", 32'(core_rst_n), 32'd1);
        core_req = 2'd1;
        step(); chk("req1_core_in", core_in, 32'hFFFF_FFFD);
        step(); chk("req2_core_in", core_in, 32'd7);
        core_req = 2'd0;
        chk("basic_underrun", 32'(underrun_cnt), 32'd0);

        // Underrun: 4 requests on an empty FIFO
        core_req = 2'd1;
        repeat (4) step();
        core_req = 2'd0;
        chk("undr_core_in_hold", core_in, 32'd7);
        chk("undr_cnt", 32'(underrun_cnt), 32'd4);
        s_valid = 1'b1; s_data = 32'd9; step(); s_valid = 1'b0;
        core_req = 2'd1; step(); core_req = 2'd0;
        chk("undr_refill_core_in", core_in, 32'd9);
        chk("undr_refill_cnt", 32'(underrun_cnt), 32'd4);

        // core_req = 2 is a no-op, even on an empty FIFO
        core_req = 2'd2; step(); core_req = 2'd0;
        chk("req2_noop_core_in", core_in, 32'd9);
        chk("req2_noop_underrun", 32'(underrun_cnt), 32'd4);

        // Output overrun: 18 strobes into a 16-deep FIFO with m_ready low
        for (int i = 1; i <= 18; i++) begin
            core_out = 32'(i); core_out_en = 2'd1; step();
        end
        core_out_en = 2'd0;
        chk("ovr_cnt", 32'(overrun_cnt), 32'd2);
        chk("ovr_sample_cnt", 32'(sample_cnt), 32'd16);
        chk("ovr_m_valid", 32'(m_valid), 32'd1);
        chk("ovr_m_data_hold", m_data, 32'd1);
        core_out = 32'd99; core_out_en = 2'd2; step(); core_out_en = 2'd0;
        chk("en2_noop_overrun", 32'(overrun_cnt), 32'd2);
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("drain_m_data_%0d", i), m_data, 32'(i));
            step();
        end
        m_ready = 1'b0;
        chk("drain_m_valid", 32'(m_valid), 32'd0);

        // Simultaneous push/pop at full input FIFO
        s_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_data = 32'(100 + i); step();
        end
        chk("full_s_ready", 32'(s_ready), 32'd0);
        s_data = 32'd200; core_req = 2'd1; step();
        s_valid = 1'b0;
        chk("full_pp_core_in", core_in, 32'd100);
        chk("full_pp_s_ready", 32'(s_ready), 32'd0);
        for (int i = 0; i < 16; i++) begin
            step();
            chk($sformatf("full_pop_%0d", i), core_in, (i < 15) ? 32'(101 + i) : 32'd200);
        end
        core_req = 2'd0;
        chk("full_after_s_ready", 32'(s_ready), 32'd1);
        chk("full_after_underrun", 32'(underrun_cnt), 32'd4);

        // Stop/drain with 3 words queued
        s_valid = 1'b1;
        s_data = 32'd11; step();
        s_data = 32'd12; step();
        s_data = 32'd13; step();
        s_valid = 1'b0;
        stop = 1'b1; step(); stop = 1'b0;
        chk("drain_busy0", 32'(busy), 32'd1);
        core_req = 2'd1;
        step(); chk("drain_pop11", core_in, 32'd11); chk("drain_busy1", 32'(busy), 32'd1);
        step(); chk("drain_pop12", core_in, 32'd12); chk("drain_busy2", 32'(busy), 32'd1);
        step(); chk("drain_pop13", core_in, 32'd13); chk("drain_busy3", 32'(busy), 32'd1);
        core_req = 2'd0;
        step();
        chk("drain_idle_busy", 32'(busy), 32'd0);
        chk("drain_idle_core_rst_n", 32'(core_rst_n), 32'd0);
        stop = 1'b1; step(); stop = 1'b0;
        chk("idle_stop_busy", 32'(busy), 32'd0);
        core_req = 2'd1; step(); core_req = 2'd0;
        chk("idle_req_underrun", 32'(underrun_cnt), 32'd4);

        // Async reset mid-run
        s_valid = 1'b1; s_data = 32'd21; step(); s_valid = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        chk("restart_clear_underrun", 32'(underrun_cnt), 32'd0);
        step();
        chk("restart_core_in", core_in, 32'd21);
        core_out = 32'd55; core_out_en = 2'd1; step(); core_out_en = 2'd0;
        chk("restart_sample_cnt", 32'(sample_cnt), 32'd1);
        chk("restart_m_valid", 32'(m_valid), 32'd1);
        core_req = 2'd1; step(); core_req = 2'd0;
        chk("restart_underrun", 32'(underrun_cnt), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("arst_m_valid", 32'(m_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        chk("arst_underrun", 32'(underrun_cnt), 32'd0);
        chk("arst_sample", 32'(sample_cnt), 32'd0);
        chk("arst_overrun", 32'(overrun_cnt), 32'd0);
        chk("arst_s_ready", 32'(s_ready), 32'd1);
        chk("arst_core_in", core_in, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
